tensor_mac_engine: RTL

Parametrised byte-serial matrix engine that computes C = A·B for N×N matrices, with an optional running accumulation of results. Operands arrive one byte per write strobe; the N×N result is returned one byte per read strobe. The engine uses one sequential multiply-accumulate unit, so each product takes one cycle. It replaces the fixed 2×2 / 4-bit multiply + accumulate + 4-in-4 TX datapath at the TPU top level.

---
 rtl/tensor_mac_engine.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/tensor_mac_engine.sv
// Byte-serial N x N matrix engine: C = A*B, or C += A*B when accu_mode is set.
// Optional define TENSOR_SAT_EN: accumulate additions saturate at 2^AW-1 instead of wrapping.
module tensor_mac_engine #(
    parameter int N  = 2,
    parameter int EW = 4,
    parameter int AW = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       wr_strobe,
    input  logic       rd_strobe,
    input  logic       clr,
    input  logic       accu_mode,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       result_ready,
    output logic       busy
);
    localparam int NN  = N * N;
    localparam int EPB = 8 / EW;
    localparam int MB  = (NN * EW + 7) / 8;
    localparam int BPE = (AW + 7) / 8;
    localparam int IW  = $clog2(N);
    localparam int CW  = $clog2(NN);
    localparam int WW  = $clog2(MB);
    localparam int BW  = $clog2(BPE);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, SEND} state_t;
    state_t state, state_next;

    logic wr_s1, wr_s2, rd_s1, rd_s2, clr_s1, clr_s2;
    logic wr_p, rd_p, clr_p;

    logic [7:0]    a_mem [MB];
    logic [7:0]    b_mem [MB];
    logic [EW-1:0] a_el  [NN];
    logic [EW-1:0] b_el  [NN];
    logic [AW-1:0] c_mem [NN];

    logic [WW-1:0] wr_cnt;
    logic [IW-1:0] i_idx, j_idx, k_idx;
    logic [CW-1:0] a_idx, b_idx, c_idx, rd_elem;
    logic [BW-1:0] rd_byte;
    logic [AW-1:0] acc, mac_base, mac_sum;
    logic [2*EW-1:0] mac_prod;
    logic [BPE*8-1:0] c_pad;
    logic [7:0]    rd_data;
    logic          accu_lat, mac_done, last_wr, last_rd;

    assign wr_p  = wr_s1 & ~wr_s2;
    assign rd_p  = rd_s1 & ~rd_s2;
    assign clr_p = clr_s1 & ~clr_s2;

    // Unpack operand bytes into elements: row-major, low bits of each byte first.
    for (genvar e = 0; e < NN; e++) begin : g_unpack
        assign a_el[e] = a_mem[e / EPB][(e % EPB) * EW +: EW];
        assign b_el[e] = b_mem[e / EPB][(e % EPB) * EW +: EW];
    end

    assign a_idx   = CW'(i_idx) * CW'(N) + CW'(k_idx);
    assign b_idx   = CW'(k_idx) * CW'(N) + CW'(j_idx);
    assign c_idx   = CW'(i_idx) * CW'(N) + CW'(j_idx);
    assign last_wr = (wr_cnt == WW'(MB - 1));
    assign last_rd = (rd_elem == CW'(NN - 1)) && (rd_byte == BW'(BPE - 1));

    assign c_pad   = (BPE * 8)'(c_mem[rd_elem]);
    assign rd_data = 8'(c_pad >> {rd_byte, 3'b000});

`ifdef TENSOR_SAT_EN
    logic [AW:0] mac_wide;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mac_prod = (2 * EW)'(a_el[a_idx]) * (2 * EW)'(b_el[b_idx]);
        mac_base = acc;
        if (k_idx == '0) mac_base = accu_lat ? c_mem[c_idx] : '0;
`ifdef TENSOR_SAT_EN
        mac_wide = {1'b0, mac_base} + (AW + 1)'(mac_prod);
        mac_sum  = mac_wide[AW] ? '1 : mac_wide[AW-1:0];
`else
        mac_sum  = mac_base + AW'(mac_prod);
`endif
    end

    always_comb begin
        state_next = state;
        if (clr_p) begin
            state_next = LOAD_A;
        end else begin
            case (state)
                LOAD_A:  if (wr_p && last_wr) state_next = LOAD_B;
                LOAD_B:  if (wr_p && last_wr) state_next = COMPUTE;
                COMPUTE: if (mac_done)        state_next = SEND;
                SEND:    if (rd_p && last_rd) state_next = LOAD_A;
                default:                      state_next = LOAD_A;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= LOAD_A;
            wr_s1  <= 1'b0;
            wr_s2  <= 1'b0;
            rd_s1  <= 1'b0;
            rd_s2  <= 1'b0;
            clr_s1 <= 1'b0;
            clr_s2 <= 1'b0;
        end else begin
            state  <= state_next;
            wr_s1  <= wr_strobe;
            wr_s2  <= wr_s1;
            rd_s1  <= rd_strobe;
            rd_s2  <= rd_s1;
            clr_s1 <= clr;
            clr_s2 <= clr_s1;
        end
    end

    assign result_ready = (state == SEND);
    assign busy         = (state == COMPUTE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt     <= '0;
            i_idx      <= '0;
            j_idx      <= '0;
            k_idx      <= '0;
            acc        <= '0;
            accu_lat   <= 1'b0;
            mac_done   <= 1'b0;
            rd_elem    <= '0;
            rd_byte    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            // NOTE: these small register-file memories are reset because C must read as zero after reset.
            for (int e = 0; e < NN; e++) c_mem[e] <= '0;
            for (int m = 0; m < MB; m++) begin
                a_mem[m] <= '0;
                b_mem[m] <= '0;
            end
        end else begin
            data_valid <= 1'b0;
            if (clr_p) begin
                wr_cnt   <= '0;
                i_idx    <= '0;
                j_idx    <= '0;
                k_idx    <= '0;
                mac_done <= 1'b0;
                rd_elem  <= '0;
                rd_byte  <= '0;
                for (int e = 0; e < NN; e++) c_mem[e] <= '0;
            end else begin
                case (state)
                    LOAD_A: if (wr_p) begin
                        a_mem[wr_cnt] <= data_in;
                        wr_cnt        <= last_wr ? '0 : wr_cnt + WW'(1);
                    end
                    LOAD_B: if (wr_p) begin
                        b_mem[wr_cnt] <= data_in;
                        wr_cnt        <= last_wr ? '0 : wr_cnt + WW'(1);
                        if (last_wr) accu_lat <= accu_mode;
                    end
                    COMPUTE: begin
                        // One extra cycle after the last MAC lets the final C write settle before SEND.
                        if (mac_done) begin
                            mac_done <= 1'b0;
                        end else begin
                            acc <= mac_sum;
                            if (k_idx == IW'(N - 1)) begin
                                c_mem[c_idx] <= mac_sum;
                                k_idx        <= '0;
                                if (j_idx == IW'(N - 1)) begin
                                    j_idx <= '0;
                                    if (i_idx == IW'(N - 1)) begin
                                        i_idx    <= '0;
                                        mac_done <= 1'b1;
                                    end else begin
                                        i_idx <= i_idx + IW'(1);
                                    end
                                end else begin
                                    j_idx <= j_idx + IW'(1);
                                end
                            end else begin
                                k_idx <= k_idx + IW'(1);
                            end
                        end
                    end
                    SEND: if (rd_p) begin
                        data_out   <= rd_data;
                        data_valid <= 1'b1;
                        if (rd_byte == BW'(BPE - 1)) begin
                            rd_byte <= '0;
                            rd_elem <= last_rd ? '0 : rd_elem + CW'(1);
                        end else begin
                            rd_byte <= rd_byte + BW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
